// File: rtl/bank_access_arbiter_if.sv
// Requester handshake and bank-array bus shared by bank_access_arbiter and its environment.
// master drives requests and the bank output line; slave is the arbiter side.
interface bank_access_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [1:0]        mem_sel;
  logic              mem_en;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_line;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_line,
    input  ack0, ack1, rdata, busy, mem_sel, mem_en, mem_addr, mem_data, mem_wen
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_line,
    output ack0, ack1, rdata, busy, mem_sel, mem_en, mem_addr, mem_data, mem_wen
  );
endinterface

// File: rtl/bank_access_arbiter.sv
// Round-robin two-port arbiter/sequencer for the 4-bank data memory; read ack at +3, write ack at +2.
// Requesters hold req until ack; only one access in flight, later requests wait in IDLE.
module bank_access_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
) (
  input logic                 CLK,
  input logic                 RSTn,
  bank_access_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]        state;
  logic              grant;
  logic              ptr;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;

  logic any_req;
  logic pick;

  // The pointer only breaks ties; a lone requester always wins.
  assign any_req = bus.req0 | bus.req1;
  assign pick    = (bus.req0 & bus.req1) ? ptr : bus.req1;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      grant     <= 1'b0;
      ptr       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= pick;
            ptr       <= ~pick;
            lat_we    <= pick ? bus.we1    : bus.we0;
            lat_addr  <= pick ? bus.addr1  : bus.addr0;
            lat_wdata <= pick ? bus.wdata1 : bus.wdata0;
            state     <= ISSUE;
          end
        end
        ISSUE:   state <= lat_we ? RESP : CAPTURE;
        CAPTURE: begin
          rdata_q <= bus.mem_line;
          state   <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Controls decode from registers only, so reset forces them inactive at once.
  assign bus.busy     = (state != IDLE);
  assign bus.mem_en   = (state == ISSUE);
  assign bus.mem_wen  = ~((state == ISSUE) & lat_we);
  assign bus.ack0     = (state == RESP) & ~grant;
  assign bus.ack1     = (state == RESP) &  grant;
  assign bus.mem_sel  = lat_addr[ADDR_W-1 -: 2];
  assign bus.mem_addr = lat_addr[ADDR_W-3:0];
  assign bus.mem_data = lat_wdata;
  assign bus.rdata    = rdata_q;

endmodule
